btn_pulse_gen: RTL and testbench

Button conditioner that sits directly upstream of the lab counter. It turns a raw, asynchronous, bouncing push-button into two signals. `pulse` is a clean single-cycle strobe that drives the counter's `enable`. `level` is the debounced button state. An optional auto-repeat emits further strobes while the button is held, so one press advances the counter exactly once and a long hold steps it at a fixed rate.

---
 rtl/btn_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/btn_pulse_gen.sv | 138 +++++++++++++
 tb/tb_btn_pulse_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path: FSM state
// encoding and the counter width helpers.
package btn_pkg;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = S_IDLE,
    PRESS_WAIT   = S_PRESS_WAIT,
    PRESSED      = S_PRESSED,
    RELEASE_WAIT = S_RELEASE_WAIT
  } btn_state_t;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 0) return 1;
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input. Both
// flops clear on the synchronous reset so the output is a known 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronizes and debounces a raw button,
// produces a one-cycle strobe per accepted press plus optional
// auto-repeat strobes while held, and a debounced level.
//
// The FSM decides "fire" and the new state on the same edge; pulse and
// level are then taken from one more flop stage so both outputs leave
// the block from dedicated registers with identical latency
// (DEBOUNCE_CYCLES+3 edges from the first high/low sample of btn).
//
// Handshake: none. pulse is a plain strobe, high for exactly one cycle;
// the consumer samples it on every clock edge, there is no back-pressure.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_EN ? (REPEAT_DELAY - 1) : 0);
  localparam logic [RW-1:0] PERIOD_LAST = RW'((REPEAT_PERIOD == 0) ? 0 : (REPEAT_PERIOD - 1));

  logic            btn_s;
  btn_state_t      state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [RW-1:0]   rcnt, rcnt_nxt;
  logic [RW-1:0]   rcnt_tgt;
  logic            use_period, use_period_nxt;
  logic            fire;
  logic            fire_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );

  // First repeat waits REPEAT_DELAY, every later one REPEAT_PERIOD.
  assign rcnt_tgt = use_period ? PERIOD_LAST : DELAY_LAST;

  // Next-state, counter updates and strobe decision.
  always_comb begin
    state_nxt      = state;
    dcnt_nxt       = dcnt;
    rcnt_nxt       = rcnt;
    use_period_nxt = use_period;
    fire           = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          dcnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt      = PRESSED;
          fire           = 1'b1;
          rcnt_nxt       = '0;
          use_period_nxt = 1'b0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          dcnt_nxt  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt == rcnt_tgt) begin
            fire           = 1'b1;
            rcnt_nxt       = '0;
            use_period_nxt = 1'b1;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the hold; the repeat counter and
        // its target stay frozen while in this state.
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (dcnt == DCNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters and the strobe decision register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dcnt       <= '0;
      rcnt       <= '0;
      use_period <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      dcnt       <= dcnt_nxt;
      rcnt       <= rcnt_nxt;
      use_period <= use_period_nxt;
      fire_q     <= fire;
    end
  end

  // Output registers: strobe and debounced level from the settled FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      pulse <= fire_q;
      level <= (state == PRESSED) || (state == RELEASE_WAIT);
    end
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: two instances (auto-repeat on and off) share
// btn/reset. A behavioural model built on run lengths of the
// synchronized button predicts pulse/level every cycle; directed
// scenarios also check pulse edge positions through an expected queue.
module tb_btn_pulse_gen;

  localparam int D   = 4;
  localparam int RD0 = 8;
  localparam int RP  = 3;

  logic clk;
  logic reset;
  logic btn;
  logic pulse0, level0;
  logic pulse1, level1;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD0),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .pulse (pulse0),
    .level (level0)
  );

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (0),
    .REPEAT_PERIOD   (RP)
  ) dut_norep (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .pulse (pulse1),
    .level (level1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- lab counter fed by pulse ----------------
  logic       lab_clr;
  logic [1:0] lab_cnt;

  always_ff @(posedge clk) begin
    if (lab_clr) lab_cnt <= 2'd0;
    else if (pulse0) lab_cnt <= lab_cnt + 2'd1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  int edge_idx;
  int fall_idx;
  int w_p0, w_p1;
  logic level0_prev;
  logic [31:0] exp_q[$];
  logic [31:0] pulse_edges[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: synchronizer delay, debounced level, length of the
  // current run of samples disagreeing with the level, and progress of
  // the repeat schedule (counts high samples preceded by a high sample
  // while the debounced level is 1).
  logic m_s1[2], m_s2[2], m_prev[2], m_lvl[2], m_fire[2], m_first[2];
  int   m_run[2], m_prog[2];
  logic e_pulse[2], e_level[2];

  task automatic model_edge(input int i, input logic b_in, input logic r, input int rd);
    logic b;
    int   tgt;
    if (r) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_prev[i] = 1'b0; m_lvl[i] = 1'b0;
      m_fire[i] = 1'b0; m_first[i] = 1'b0; m_run[i] = 0; m_prog[i] = 0;
      e_pulse[i] = 1'b0; e_level[i] = 1'b0;
    end else begin
      e_pulse[i] = m_fire[i];
      e_level[i] = m_lvl[i];
      b = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = b_in;
      m_fire[i] = 1'b0;
      if (rd != 0 && m_lvl[i] && b && m_prev[i]) begin
        m_prog[i]++;
        tgt = m_first[i] ? RP : rd;
        if (m_prog[i] == tgt) begin
          m_fire[i] = 1'b1; m_prog[i] = 0; m_first[i] = 1'b1;
        end
      end
      if (b != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      // Entering a wait state costs one sample, then D counted samples.
      if (m_run[i] == D + 1) begin
        m_lvl[i] = b;
        m_run[i] = 0;
        if (b) begin
          m_fire[i] = 1'b1; m_prog[i] = 0; m_first[i] = 1'b0;
        end
      end
      m_prev[i] = b;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic b, input logic r);
    btn = b;
    reset = r;
    @(posedge clk);
    model_edge(0, b, r, RD0);
    model_edge(1, b, r, 0);
    edge_idx = cyc - t0;
    cyc++;
    #1;
    chk("pulse", pulse0, e_pulse[0]);
    chk("level", level0, e_level[0]);
    chk("pulse_norep", pulse1, e_pulse[1]);
    chk("level_norep", level1, e_level[1]);
    if (pulse0) begin
      pulse_edges.push_back(edge_idx);
      w_p0++;
    end
    if (pulse1) w_p1++;
    if (level0_prev && !level0) fall_idx = edge_idx;
    level0_prev = level0;
    @(negedge clk);
  endtask

  task automatic mark();
    t0 = cyc;
    pulse_edges.delete();
    exp_q.delete();
    fall_idx = -1;
    w_p0 = 0;
    w_p1 = 0;
  endtask

  task automatic check_edges(input string tag);
    chk({tag, "_count"}, pulse_edges.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulse_edges.size(); k++)
      chk({tag, "_edge"}, pulse_edges[k], exp_q[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi, lo, base, rel, late, len;
    logic v;
    btn = 1'b0;
    reset = 1'b1;
    lab_clr = 1'b1;
    level0_prev = 1'b0;
    mark();

    // Reset state
    repeat (3) step(1'b0, 1'b1);
    chk("rst_pulse", pulse0, 0);
    chk("rst_level", level0, 0);
    repeat (4) step(1'b0, 1'b0);

    // Reset while held: outputs drop, press re-debounced afterwards
    repeat (10) step(1'b1, 1'b0);
    chk("hold_level", level0, 1);
    repeat (3) begin
      step(1'b1, 1'b1);
      chk("rst_hold_pulse", pulse0, 0);
      chk("rst_hold_level", level0, 0);
    end
    mark();
    repeat (12) step(1'b1, 1'b0);
    exp_q.push_back(7);
    check_edges("rst_repress");
    repeat (12) step(1'b0, 1'b0);

    // Clean press with auto-repeat, then release
    mark();
    repeat (18) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    exp_q.push_back(7);
    exp_q.push_back(15);
    exp_q.push_back(18);
    check_edges("clean");
    chk("clean_fall", fall_idx, 18 + 7);

    // Bounce before a stable press
    mark();
    for (int k = 0; k < 5; k++) begin
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      repeat (hi) step(1'b1, 1'b0);
      repeat (lo) step(1'b0, 1'b0);
    end
    base = cyc - t0;
    repeat (10) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    exp_q.push_back(base + 7);
    check_edges("bounce");

    // Release bounce during a hold, then sustained release
    mark();
    repeat (10) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    rel = cyc - t0;
    repeat (12) step(1'b0, 1'b0);
    chk("relb_fall", fall_idx, rel + 7);
    late = 0;
    foreach (pulse_edges[k]) if (pulse_edges[k] >= rel + 3) late++;
    chk("relb_release_pulse", late, 0);

    // Counter integration: three presses -> 3, fourth wraps to 0
    lab_clr = 1'b1;
    step(1'b0, 1'b0);
    lab_clr = 1'b0;
    repeat (3) begin
      repeat (10) step(1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0);
    end
    chk("lab_cnt3", lab_cnt, 3);
    repeat (10) step(1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b0);
    chk("lab_cnt_wrap", lab_cnt, 0);

    // Long hold: repeat-disabled instance pulses once; repeating one
    // pulses at 7, 15, then every 3 while samples stay high (to edge 101)
    mark();
    repeat (100) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    chk("norep_pulses", w_p1, 1);
    chk("rep_pulses", w_p0, 31);
    chk("norep_level_end", level1, 0);

    // Random runs with occasional resets
    for (int k = 0; k < 400; k++) begin
      len = $urandom_range(1, 8);
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 3)) step(v, 1'b1);
      end
      repeat (len) step(v, 1'b0);
    end
    repeat (12) step(1'b0, 1'b0);
    chk("final_level", level0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
